// File: rtl/ws281x_pkg.sv
// ---------------------------------------------------------------------------
// ws281x_pkg
// Shared definitions for the ws281x port scheduler: scheduler state
// encoding, pixel word width and the width of the latch/reset period.
// ---------------------------------------------------------------------------
package ws281x_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SEND  = 2'd2,
      LATCH = 2'd3
   } ws_state_t;

   localparam int unsigned WS_BITS      = 24;
   localparam int unsigned RST_PERIOD_W = 16;

endpackage

// File: rtl/ws281x_sched_if.sv
// ---------------------------------------------------------------------------
// ws281x_sched_if
// Handshake between the port scheduler and the shared bit-timing engine.
//   eng_start : one-cycle pulse launching a word   (scheduler -> engine)
//   eng_data  : word to send, valid with eng_start (scheduler -> engine)
//   eng_done  : one-cycle pulse, word finished     (engine -> scheduler)
// master = scheduler side, slave = engine side.
// ---------------------------------------------------------------------------
interface ws281x_sched_if;
   import ws281x_pkg::*;

   logic               eng_start;
   logic [WS_BITS-1:0] eng_data;
   logic               eng_done;

   modport master (output eng_start, output eng_data, input eng_done);
   modport slave  (input eng_start, input eng_data, output eng_done);

endinterface

// File: rtl/ws281x_rr_arb.sv
// ---------------------------------------------------------------------------
// ws281x_rr_arb
// Purely combinational round-robin arbiter. The search starts at ptr and
// wraps from NP-1 back to 0; the first requesting port wins.
//   req : per-port request
//   ptr : first index to consider
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted port (zero when no request)
//   any : at least one request present
// ---------------------------------------------------------------------------
module ws281x_rr_arb #(
   parameter  int unsigned NP = 2,
   localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1
) (
   input  logic [NP-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [NP-1:0] gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      // Step i visits port (ptr+i) mod NP; the inner loop keeps all bit
      // selects constant after unrolling.
      for (int unsigned i = 0; i < NP; i++) begin
         for (int unsigned j = 0; j < NP; j++) begin
            if (!any && (j == (32'(ptr) + i) % NP) && req[j]) begin
               any    = 1'b1;
               gnt[j] = 1'b1;
               idx    = PW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/ws281x_sched.sv
// ---------------------------------------------------------------------------
// ws281x_sched
// Shares one ws281x bit-timing engine between NP output ports. An idle
// scheduler grants an eligible port (enabled and FIFO not empty) by
// round-robin, streams that port's words back-to-back to the engine while
// it stays eligible, then holds the line for the latch/reset period before
// moving the round-robin pointer past the port just served.
//   mclk, h_reset_n  : clock, asynchronous active-low reset
//   cfg_reset_period : latch low time in mclk cycles (period+1 LATCH cycles)
//   port_enb         : per-port enable
//   port_dval        : per-port FIFO not-empty
//   port_data        : per-port FIFO head, port p at [24p+23:24p]
//   port_rd          : one-cycle FIFO pop, issued in LOAD
//   eng              : engine handshake (start/data out, done in)
//   port_sel         : one-hot owner of the serial line, zero when idle
//   cur_port         : index of the current owner
//   sched_busy       : state is not IDLE
// ---------------------------------------------------------------------------
module ws281x_sched
   import ws281x_pkg::*;
#(
   parameter  int unsigned NP = 2,
   localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1
) (
   input  logic                    mclk,
   input  logic                    h_reset_n,
   input  logic [RST_PERIOD_W-1:0] cfg_reset_period,
   input  logic [NP-1:0]           port_enb,
   input  logic [NP-1:0]           port_dval,
   input  logic [NP*WS_BITS-1:0]   port_data,
   output logic [NP-1:0]           port_rd,
   ws281x_sched_if.master          eng,
   output logic [NP-1:0]           port_sel,
   output logic [PW-1:0]           cur_port,
   output logic                    sched_busy
);

   ws_state_t               state, state_d;
   logic [PW-1:0]           rr_ptr, rr_ptr_d;
   logic [PW-1:0]           cur_port_d;
   logic [NP-1:0]           port_sel_d;
   logic [NP-1:0]           port_rd_d;
   logic [RST_PERIOD_W-1:0] lat_cnt, lat_cnt_d;
   logic                    eng_start_q, eng_start_d;
   logic [WS_BITS-1:0]      eng_data_w;
   logic                    cur_elig;

   logic [NP-1:0]           eligible;
   logic [NP-1:0]           gnt;
   logic [PW-1:0]           gnt_idx;
   logic                    gnt_any;

   assign eligible = port_enb & port_dval;

   ws281x_rr_arb #(.NP(NP)) u_arb (
      .req (eligible),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   always_comb begin
      state_d    = state;
      rr_ptr_d   = rr_ptr;
      cur_port_d = cur_port;
      port_sel_d = port_sel;
      lat_cnt_d  = lat_cnt;
      eng_data_w = '0;
      // port_sel is one-hot on cur_port outside IDLE, so it doubles as the
      // owner's eligibility mask.
      cur_elig   = |(eligible & port_sel);

      for (int unsigned p = 0; p < NP; p++) begin
         if (PW'(p) == cur_port) begin
            eng_data_w = port_data[p*WS_BITS +: WS_BITS];
         end
      end

      case (state)
         IDLE: begin
            if (gnt_any) begin
               state_d    = LOAD;
               cur_port_d = gnt_idx;
               port_sel_d = gnt;
            end
         end
         LOAD: begin
            state_d = SEND;
         end
         SEND: begin
            if (eng.eng_done) begin
               if (cur_elig) begin
                  state_d = LOAD;
               end else begin
                  state_d   = LATCH;
                  lat_cnt_d = cfg_reset_period;
               end
            end
         end
         LATCH: begin
            if (lat_cnt == '0) begin
               state_d    = IDLE;
               port_sel_d = '0;
               rr_ptr_d   = (cur_port == PW'(NP - 1)) ? '0 : cur_port + PW'(1);
            end else begin
               lat_cnt_d = lat_cnt - RST_PERIOD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Start and pop are registered: decode them from the next state so
      // they are high for exactly the LOAD cycle.
      eng_start_d = (state_d == LOAD);
      port_rd_d   = eng_start_d ? port_sel_d : '0;
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         cur_port    <= '0;
         lat_cnt     <= '0;
         port_sel    <= '0;
         port_rd     <= '0;
         eng_start_q <= 1'b0;
      end else begin
         state       <= state_d;
         rr_ptr      <= rr_ptr_d;
         cur_port    <= cur_port_d;
         lat_cnt     <= lat_cnt_d;
         port_sel    <= port_sel_d;
         port_rd     <= port_rd_d;
         eng_start_q <= eng_start_d;
      end
   end

   assign eng.eng_start = eng_start_q;
   assign eng.eng_data  = eng_data_w;
   assign sched_busy    = (state != IDLE);

endmodule

// File: tb/tb_ws281x_sched.sv
// ---------------------------------------------------------------------------
// tb_ws281x_sched
// Self-checking bench for ws281x_sched (NP=2). Port FIFOs and the bit-timing
// engine are modelled with queues and a countdown; a transaction-level
// reference (owner / launching / waiting / hold-cycles-left) predicts the
// scheduler outputs, and every cycle the outputs are compared with it.
// Directed scenarios add hand-computed expectations; a random phase follows.
// ---------------------------------------------------------------------------
module tb_ws281x_sched;
   import ws281x_pkg::*;

   localparam int unsigned NP = 2;
   localparam int unsigned PW = 1;

   logic                mclk = 1'b0;
   logic                h_reset_n = 1'b0;
   logic [15:0]         cfg_reset_period;
   logic [NP-1:0]       port_enb;
   logic [NP-1:0]       port_dval;
   logic [NP*24-1:0]    port_data;
   logic [NP-1:0]       port_rd;
   logic [NP-1:0]       port_sel;
   logic [PW-1:0]       cur_port;
   logic                sched_busy;

   ws281x_sched_if eng();

   ws281x_sched #(.NP(NP)) dut (
      .mclk             (mclk),
      .h_reset_n        (h_reset_n),
      .cfg_reset_period (cfg_reset_period),
      .port_enb         (port_enb),
      .port_dval        (port_dval),
      .port_data        (port_data),
      .port_rd          (port_rd),
      .eng              (eng),
      .port_sel         (port_sel),
      .cur_port         (cur_port),
      .sched_busy       (sched_busy)
   );

   always #5 mclk = ~mclk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [23:0] fifo [NP][$];

   // reference model
   int m_owner;   // -1: nobody owns the line
   int m_cur;
   int m_ptr;
   int m_hold;    // hold cycles left, counting the current one
   bit m_launch;
   bit m_wait;

   // engine model
   int unsigned eng_cnt   = 0;
   int unsigned eng_delay = 3;
   bit          rand_delay = 1'b0;

   // observation log
   int start_cyc[$];
   int done_cyc[$];
   int start_port[$];
   int rd0_cnt, rd1_cnt, frames, idle_cyc;
   bit prev_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_fifo();
      for (int unsigned p = 0; p < NP; p++) begin
         port_dval[p]        = (fifo[p].size() > 0);
         port_data[p*24 +: 24] = (fifo[p].size() > 0) ? fifo[p][0] : 24'h0;
      end
   endtask

   task automatic push(input int unsigned p, input logic [23:0] w);
      fifo[p].push_back(w);
      drive_fifo();
   endtask

   task automatic flush();
      for (int unsigned p = 0; p < NP; p++) fifo[p].delete();
      drive_fifo();
   endtask

   function automatic void model_reset();
      m_owner  = -1;
      m_cur    = 0;
      m_ptr    = 0;
      m_hold   = 0;
      m_launch = 1'b0;
      m_wait   = 1'b0;
   endfunction

   function automatic bit elig(input int p);
      return port_enb[p] && (fifo[p].size() > 0);
   endfunction

   // Advance the reference by one clock using the values present before it.
   function automatic void model_step();
      bit found;
      int p;
      if (!h_reset_n) begin
         model_reset();
         return;
      end
      if (m_owner < 0) begin
         found = 1'b0;
         for (int i = 0; i < int'(NP); i++) begin
            p = (m_ptr + i) % int'(NP);
            if (!found && elig(p)) begin
               found    = 1'b1;
               m_owner  = p;
               m_cur    = p;
               m_launch = 1'b1;
            end
         end
      end else if (m_launch) begin
         m_launch = 1'b0;
         m_wait   = 1'b1;
      end else if (m_wait) begin
         if (eng.eng_done === 1'b1) begin
            m_wait = 1'b0;
            if (elig(m_owner)) m_launch = 1'b1;
            else               m_hold   = int'(cfg_reset_period) + 1;
         end
      end else begin
         m_hold--;
         if (m_hold == 0) begin
            m_ptr   = (m_owner + 1) % int'(NP);
            m_owner = -1;
         end
      end
   endfunction

   task automatic compare();
      logic [31:0] sel_exp;
      sel_exp = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      chk("busy",      32'(sched_busy),    32'(m_owner >= 0));
      chk("port_sel",  32'(port_sel),      sel_exp);
      chk("cur_port",  32'(cur_port),      32'(m_cur));
      chk("eng_start", 32'(eng.eng_start), 32'(m_launch));
      chk("port_rd",   32'(port_rd),       m_launch ? sel_exp : 32'd0);
      if (m_launch && fifo[m_owner].size() > 0)
         chk("eng_data", 32'(eng.eng_data), 32'(fifo[m_owner][0]));
   endtask

   task automatic tick();
      logic [NP-1:0] pre_rd;
      logic          pre_start;
      logic          nxt_done;
      pre_rd    = port_rd;
      pre_start = eng.eng_start;
      model_step();
      @(posedge mclk);
      #1;
      cyc++;
      for (int unsigned p = 0; p < NP; p++)
         if (pre_rd[p] === 1'b1 && fifo[p].size() > 0) void'(fifo[p].pop_front());
      nxt_done = 1'b0;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) nxt_done = 1'b1;
      end
      if (pre_start === 1'b1) eng_cnt = rand_delay ? $urandom_range(1, 5) : eng_delay;
      eng.eng_done = nxt_done;
      drive_fifo();
      #1;
      compare();
      if (eng.eng_start === 1'b1) begin
         start_cyc.push_back(cyc);
         start_port.push_back(int'(cur_port));
      end
      if (eng.eng_done === 1'b1) done_cyc.push_back(cyc);
      if (port_rd[0] === 1'b1) rd0_cnt++;
      if (port_rd[1] === 1'b1) rd1_cnt++;
      if (prev_busy && sched_busy === 1'b0) begin
         frames++;
         idle_cyc = cyc;
      end
      prev_busy = (sched_busy === 1'b1);
   endtask

   task automatic clear_log();
      start_cyc.delete();
      done_cyc.delete();
      start_port.delete();
      rd0_cnt   = 0;
      rd1_cnt   = 0;
      frames    = 0;
      idle_cyc  = 0;
      prev_busy = (sched_busy === 1'b1);
   endtask

   task automatic wait_frames(input string name, input int n, input int bound);
      int g;
      g = 0;
      while (frames < n && g < bound) begin
         tick();
         g++;
      end
      chk(name, 32'(frames), 32'(n));
   endtask

   task automatic reset_now();
      h_reset_n    = 1'b0;
      model_reset();
      eng_cnt      = 0;
      eng.eng_done = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int unsigned p;
      model_reset();
      cfg_reset_period = 16'd16;
      port_enb         = '0;
      eng.eng_done     = 1'b0;
      flush();
      repeat (3) tick();
      chk("rst_busy",      32'(sched_busy),    32'd0);
      chk("rst_port_sel",  32'(port_sel),      32'd0);
      chk("rst_port_rd",   32'(port_rd),       32'd0);
      chk("rst_eng_start", 32'(eng.eng_start), 32'd0);
      chk("rst_cur_port",  32'(cur_port),      32'd0);
      h_reset_n = 1'b1;
      tick();

      // Single pixel, 16-cycle latch period
      eng_delay = 3;
      clear_log();
      port_enb = 2'b01;
      push(0, 24'hA5A5A5);
      tick();
      chk("t1_start_latency", 32'(eng.eng_start), 32'd1);
      chk("t1_eng_data",      32'(eng.eng_data),  32'hA5A5A5);
      chk("t1_port_rd",       32'(port_rd),       32'd1);
      chk("t1_port_sel",      32'(port_sel),      32'd1);
      wait_frames("t1_frames", 1, 200);
      chk("t1_starts", 32'(start_cyc.size()), 32'd1);
      chk("t1_rd0",    32'(rd0_cnt),          32'd1);
      if (done_cyc.size() > 0)
         chk("t1_latch_len", 32'(idle_cyc - done_cyc[done_cyc.size()-1] - 1), 32'd17);
      else
         chk("t1_done_seen", 32'd0, 32'd1);

      // Burst of three words on port 1
      cfg_reset_period = 16'd4;
      eng_delay = 2;
      port_enb = 2'b10;
      clear_log();
      push(1, 24'h111111);
      push(1, 24'h222222);
      push(1, 24'h333333);
      wait_frames("t2_frames", 1, 300);
      chk("t2_starts", 32'(start_cyc.size()), 32'd3);
      chk("t2_rd1",    32'(rd1_cnt),          32'd3);
      if (start_cyc.size() == 3 && done_cyc.size() >= 2) begin
         chk("t2_gap1", 32'(start_cyc[1] - done_cyc[0]), 32'd1);
         chk("t2_gap2", 32'(start_cyc[2] - done_cyc[1]), 32'd1);
      end else begin
         chk("t2_event_count", 32'(done_cyc.size()), 32'd3);
      end
      if (done_cyc.size() > 0)
         chk("t2_latch_len", 32'(idle_cyc - done_cyc[done_cyc.size()-1] - 1), 32'd5);

      // Fairness from reset: two words on each port
      reset_now();
      repeat (2) tick();
      cfg_reset_period = 16'd3;
      port_enb = 2'b11;
      push(0, 24'h0A0001);
      push(0, 24'h0A0002);
      push(1, 24'h0B0001);
      push(1, 24'h0B0002);
      h_reset_n = 1'b1;
      clear_log();
      wait_frames("t3_frames", 2, 400);
      chk("t3_starts", 32'(start_cyc.size()), 32'd4);
      if (start_port.size() == 4) begin
         chk("t3_order0", 32'(start_port[0]), 32'd0);
         chk("t3_order1", 32'(start_port[1]), 32'd0);
         chk("t3_order2", 32'(start_port[2]), 32'd1);
         chk("t3_order3", 32'(start_port[3]), 32'd1);
      end
      chk("t3_rr_ptr", 32'(dut.rr_ptr), 32'd0);

      // Disable mid-word: port 0 holds four words
      cfg_reset_period = 16'd3;
      eng_delay = 4;
      port_enb = 2'b01;
      clear_log();
      for (int i = 0; i < 4; i++) push(0, 24'hC00000 + 24'(i));
      tick();
      tick();
      port_enb = 2'b00;
      wait_frames("t4_frames", 1, 200);
      chk("t4_starts",  32'(start_cyc.size()), 32'd1);
      chk("t4_rd0",     32'(rd0_cnt),          32'd1);
      chk("t4_fifo_left", 32'(fifo[0].size()), 32'd3);
      flush();

      // Reset at latch counter 5
      cfg_reset_period = 16'd16;
      eng_delay = 2;
      port_enb = 2'b01;
      clear_log();
      push(0, 24'h5A5A5A);
      g = 0;
      while (done_cyc.size() == 0 && g < 100) begin
         tick();
         g++;
      end
      chk("t5_done_seen", 32'(done_cyc.size()), 32'd1);
      repeat (12) tick();
      chk("t5_lat_cnt", 32'(dut.lat_cnt), 32'd5);
      #3;
      reset_now();
      #1;
      chk("t5_rst_busy",      32'(sched_busy),    32'd0);
      chk("t5_rst_port_sel",  32'(port_sel),      32'd0);
      chk("t5_rst_port_rd",   32'(port_rd),       32'd0);
      chk("t5_rst_eng_start", 32'(eng.eng_start), 32'd0);
      chk("t5_rst_cur_port",  32'(cur_port),      32'd0);
      flush();
      port_enb = 2'b10;
      push(1, 24'h777777);
      repeat (2) tick();
      h_reset_n = 1'b1;
      clear_log();
      tick();
      chk("t5_grant_port",  32'(cur_port),      32'd1);
      chk("t5_grant_sel",   32'(port_sel),      32'd2);
      chk("t5_grant_start", 32'(eng.eng_start), 32'd1);
      wait_frames("t5_frames", 1, 200);

      // Zero latch period, then a spurious done while idle
      cfg_reset_period = 16'd0;
      eng_delay = 1;
      port_enb = 2'b01;
      clear_log();
      push(0, 24'h0F0F0F);
      wait_frames("t6_frames", 1, 100);
      if (done_cyc.size() > 0)
         chk("t6_latch_len", 32'(idle_cyc - done_cyc[done_cyc.size()-1] - 1), 32'd1);
      eng.eng_done = 1'b1;
      tick();
      chk("t6_spurious_busy",  32'(sched_busy),    32'd0);
      chk("t6_spurious_start", 32'(eng.eng_start), 32'd0);
      tick();
      chk("t6_spurious_idle", 32'(sched_busy), 32'd0);

      // Random traffic
      rand_delay = 1'b1;
      port_enb = 2'b11;
      cfg_reset_period = 16'd2;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            p = $urandom_range(0, NP - 1);
            if (fifo[p].size() < 6) push(p, 24'($urandom()));
         end
         if ($urandom_range(0, 19) == 0) begin
            p = $urandom_range(0, NP - 1);
            port_enb[p] = ~port_enb[p];
         end
         if ($urandom_range(0, 29) == 0) cfg_reset_period = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 59) == 0) eng.eng_done = 1'b1;
         tick();
      end

      // Drain
      port_enb = 2'b11;
      g = 0;
      while ((fifo[0].size() + fifo[1].size() > 0 || sched_busy !== 1'b0) && g < 3000) begin
         tick();
         g++;
      end
      chk("drain_idle",  32'(sched_busy), 32'd0);
      chk("drain_fifo0", 32'(fifo[0].size()), 32'd0);
      chk("drain_fifo1", 32'(fifo[1].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ws281x_sched.md
WS281X_SCHED -- requirements
Module: ws281x_sched

Interface
REQ-001 The module SHALL have parameter NP, default 2, meaning the number of ws281x ports sharing one bit-timing engine (1..8).
REQ-002 The module SHALL have localparam PW = max(1, $clog2(NP)), meaning the width of the port index.
REQ-003 The module SHALL have port: mclk  input  1  system clock.
REQ-004 The module SHALL have port: h_reset_n  input  1  reset, asynchronous, active-low; clock mclk.
REQ-005 The module SHALL have port: cfg_reset_period  input  16  latch/reset low time in mclk cycles.
REQ-006 The module SHALL have port: port_enb  input  NP  per-port enable.
REQ-007 The module SHALL have port: port_dval  input  NP  per-port FIFO not-empty.
REQ-008 The module SHALL have port: port_data  input  NP*24  per-port FIFO head (first-word-fall-through); port p occupies bits [24p+23:24p].
REQ-009 The module SHALL have port: port_rd  output  NP  one-cycle FIFO pop per port.
REQ-010 The module SHALL have port: eng_start  output  1  one-cycle pulse launching a 24-bit word on the shared engine.
REQ-011 The module SHALL have port: eng_data  output  24  word for the engine, valid while eng_start=1.
REQ-012 The module SHALL have port: eng_done  input  1  one-cycle pulse when the engine finishes 24 bits.
REQ-013 The module SHALL have port: port_sel  output  NP  one-hot owner of the serial line (all zero = no owner).
REQ-014 The module SHALL have port: cur_port  output  PW  index of the current owner.
REQ-015 The module SHALL have port: sched_busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly four states:
- IDLE
- LOAD
- SEND
- LATCH
REQ-017 Port p SHALL be eligible when port_enb[p] & port_dval[p].
REQ-018 In IDLE with one or more ports eligible, the FSM SHALL grant one port by round-robin and enter LOAD next cycle.
- The search SHALL start at rr_ptr and wrap from NP-1 to 0.
- The grant SHALL register cur_port and port_sel.
REQ-019 LOAD SHALL last exactly one cycle, in which:
- eng_start=1;
- eng_data = port_data of cur_port;
- port_rd[cur_port]=1.
The FSM SHALL then enter SEND.
REQ-020 Latency: eng_start SHALL assert exactly one cycle after IDLE samples an eligible port.
REQ-021 SEND SHALL wait for eng_done; eng_done in any other state SHALL be ignored.
REQ-022 On eng_done in SEND:
- if cur_port is still eligible, go to LOAD (back-to-back pixels, no gap);
- otherwise go to LATCH and load the latch counter with cfg_reset_period.
REQ-023 LATCH SHALL count down once per cycle.
- On counter == 0, go to IDLE and set rr_ptr = (cur_port+1) mod NP.
- cfg_reset_period = 0 SHALL give a one-cycle LATCH.
REQ-024 port_sel SHALL stay one-hot on cur_port from LOAD through the last LATCH cycle, and SHALL be zero in IDLE.
REQ-025 Deasserting port_enb[cur_port] during SEND SHALL NOT abort the word in flight; the FSM SHALL enter LATCH on eng_done.
REQ-026 The FIFO running empty mid-frame SHALL end the frame, with LATCH entered on the next eng_done.
REQ-027 Changing cfg_reset_period during LATCH SHALL NOT affect the counter already loaded.
REQ-028 At most one port_rd bit SHALL be high in any cycle, and only in LOAD.
REQ-029 A port SHALL NOT be granted again while another port is eligible, because rr_ptr advances after every LATCH.
REQ-030 eng_start and port_rd SHALL be registered outputs; eng_data MAY be a combinational mux held stable in LOAD.

Reset
REQ-031 Asserting h_reset_n low SHALL immediately set, at any point including mid-SEND or mid-LATCH:
- state = IDLE;
- rr_ptr = 0;
- cur_port = 0;
- latch counter = 0;
- port_sel = 0;
- port_rd = 0;
- eng_start = 0;
- sched_busy = 0.
REQ-032 After reset is released, the first grant SHALL go to the lowest-indexed eligible port.

Structure
REQ-033 A shared package ws281x_pkg SHALL hold:
- the state enum (IDLE/LOAD/SEND/LATCH);
- localparam WS_BITS = 24;
- the width of cfg_reset_period.
REQ-034 Round-robin selection SHALL be a separate sub-module, ws281x_rr_arb (request NP, pointer PW, grant one-hot plus index, purely combinational).
REQ-035 Everything else SHALL be in a single always_ff plus one always_comb, targeting 150-250 lines.

Verification
REQ-036 Single pixel: NP=2, port0 enb=1, one word 24'hA5A5A5, cfg_reset_period=16.
- Expect eng_start one cycle after dval, with eng_data=24'hA5A5A5 and port_rd[0] pulsed once.
- After eng_done, expect port_sel=2'b01 for 17 cycles, then IDLE.
REQ-037 Burst: port1 holds 3 words.
- Expect 3 eng_start pulses, each exactly one cycle after the preceding eng_done.
- Expect no LATCH between words, then a single LATCH.
REQ-038 Fairness: both ports enabled, each with 2 words queued, from reset.
- Expect order: port0 ×2, LATCH, port1 ×2, LATCH.
- rr_ptr SHALL read 0 after the sequence.
REQ-039 Disable mid-word: clear port_enb[0] during SEND while port0 holds 4 words.
- The current word SHALL complete.
- LATCH SHALL follow, with no further port_rd[0].
REQ-040 Reset mid-LATCH: assert h_reset_n low at LATCH counter=5.
- All outputs SHALL be zero in the same cycle.
- After release with port1 eligible only, port1 SHALL be granted.
REQ-041 Zero latch: cfg_reset_period=0, one word.
- Expect LATCH for exactly one cycle.
- A spurious eng_done injected in IDLE SHALL cause no state change.
